uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter PRESCALE_W, default 16, width of prescale input.
REQ-003 SHALL have port HCLK  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port HRESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wdata  input  8  byte to enqueue.
REQ-006 SHALL have port wr  input  1  push strobe, one byte per cycle.
REQ-007 SHALL have port en  input  1  transmitter enable.
REQ-008 SHALL have port prescale  input  PRESCALE_W  bit period minus one, in HCLK cycles.
REQ-009 SHALL have port stop2  input  1  1 = two stop bits, 0 = one.
REQ-010 SHALL have port ovf_clr  input  1  clears overflow flag.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-013 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of each frame.
REQ-017 SHALL have port ovf  output  1  sticky: push attempted while full.

Function
REQ-018 Frame format SHALL be 8N1 (or 8N2 with stop2): start 0, data bits LSB first, stop 1.
REQ-019 Each bit SHALL last exactly prescale+1 HCLK cycles; prescale=0 gives 1-cycle bits.
REQ-020 prescale and stop2 SHALL be captured at frame start and held for the whole frame.
REQ-021 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-022 IDLE -> START SHALL occur on the cycle where en=1 and empty=0. The head byte is popped into the shift register on that edge. tx goes 0 on the next cycle.
REQ-023 START -> DATA after one bit period; DATA lasts 8 bit periods; a 3-bit index counts 0..7.
REQ-024 DATA -> STOP after bit 7. STOP lasts 1 or 2 bit periods per captured stop2.
REQ-025 done SHALL pulse on the last cycle of STOP.
REQ-026 At end of STOP with en=1 and empty=0, next state SHALL be START with a pop on the same edge: no idle gap between frames.
REQ-027 At end of STOP with en=0 or empty=1, next state SHALL be IDLE.
REQ-028 Deasserting en mid-frame SHALL NOT abort the frame; it completes, then IDLE.
REQ-029 wr with full=0 SHALL write wdata at the tail; count increments unless a pop occurs the same cycle.
REQ-030 wr with full=1 SHALL be dropped and SHALL set ovf. Exception: a pop on the same cycle frees a slot, so the write is accepted, count stays DEPTH, and ovf is not set.
REQ-031 Push and pop in the same cycle with 0 < count < DEPTH: count unchanged.
REQ-032 Pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count, never ambiguous.
REQ-033 ovf SHALL clear on ovf_clr. If ovf_clr and an overflow occur in the same cycle, set wins.
REQ-034 Output tx SHALL be registered (glitch-free).

Reset
REQ-035 HRESET=1 SHALL immediately force state IDLE, tx=1, busy=0, done=0, ovf=0, count=0, empty=1, full=0, pointers 0.
REQ-036 A frame interrupted by reset SHALL be discarded; FIFO contents are lost.
REQ-037 After HRESET falls, the first push SHALL be accepted on the first rising edge.

Verification
REQ-038 prescale=15, stop2=0, en=1, push 0x55 -> tx low 16 cycles, then 1,0,1,0,1,0,1,0 for 16 cycles each, high 16 cycles. done pulses at cycle 160 after pop. Byte 0x55 is decoded by a 16-cycle-per-bit line monitor.
REQ-039 en=0, push 9 bytes 0x00..0x08 with DEPTH=8 -> full=1 after 8, 9th dropped, ovf=1, count=8. Then en=1 -> 8 frames 0x00..0x07 back-to-back with no idle cycles, then empty=1, busy=0.
REQ-040 stop2=1, prescale=3, push 0xA3 -> frame is 44 cycles (11 bits x 4). tx high for the final 8 cycles.
REQ-041 full=1 while the FSM pops at end of STOP, with a simultaneous push -> write accepted, count stays 8, ovf stays 0. ovf_clr with a simultaneous drop -> ovf remains 1.
REQ-042 Assert HRESET during DATA bit 4 -> tx=1 asynchronously, count=0, busy=0. No done pulse.
REQ-043 Change prescale from 15 to 3 mid-frame -> current frame keeps 16-cycle bits; the next frame uses 4-cycle bits.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO feeding an 8N1/8N2 UART transmitter.
//
//   Parameters
//     DEPTH       FIFO entries (power of two, >= 2)
//     PRESCALE_W  width of the prescale input
//
//   Ports
//     HCLK        sole clock, rising edge
//     HRESET      asynchronous, active-high reset
//     wdata/wr    byte to enqueue / push strobe (one byte per cycle)
//     en          transmitter enable
//     prescale    bit period minus one, in HCLK cycles
//     stop2       1 = two stop bits, 0 = one
//     ovf_clr     clears the sticky overflow flag
//     tx          registered serial line, idle high
//     full/empty  FIFO holds DEPTH / 0 bytes
//     count       FIFO occupancy
//     busy        FSM is in any state other than IDLE
//     done        one-cycle pulse on the last cycle of each frame
//     ovf         sticky: a push was attempted while full
//     dbg_state   current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
//   Handshake: wr is a strobe with no ready. A write is accepted when the
//   FIFO is not full, or when it is full but the transmitter pops on the
//   same edge. Any other write is dropped and sets ovf.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [7:0]             wdata,
    input  logic                   wr,
    input  logic                   en,
    input  logic [PRESCALE_W-1:0]  prescale,
    input  logic                   stop2,
    input  logic                   ovf_clr,
    output logic                   tx,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [1:0]             dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  stop2_q, stop2_d;
    logic                  stop_second_q, stop_second_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [7:0] mem [DEPTH];

    logic full_w;
    logic empty_w;
    logic bit_end;
    logic frame_end;
    logic pop;
    logic push;

    // Full/empty come from the occupancy counter, so equal pointers are
    // never ambiguous.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        presc_d       = presc_q;
        stop2_d       = stop2_q;
        stop_second_d = stop_second_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        tx_d          = tx_q;
        ovf_d         = ovf_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        bit_end   = (cnt_q == presc_q);
        frame_end = (state_q == STOP) && bit_end && (!stop2_q || stop_second_q);
        // A pop starts a frame, either from IDLE or directly out of the
        // final stop bit so that consecutive frames have no idle gap.
        pop  = en && !empty_w && ((state_q == IDLE) || frame_end);
        // When full, a same-edge pop frees the slot the write lands in.
        push = wr && (!full_w || pop);

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    cnt_d = cnt_q + PRESCALE_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d       = STOP;
                        tx_d          = 1'b1;
                        stop_second_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + PRESCALE_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (frame_end) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        stop_second_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + PRESCALE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start: load the head byte and freeze the bit timing and
        // stop-bit count for the whole frame.
        if (pop) begin
            state_d       = START;
            shift_d       = mem[rd_ptr_q];
            tx_d          = 1'b0;
            cnt_d         = '0;
            presc_d       = prescale;
            stop2_d       = stop2;
            stop_second_d = 1'b0;
            idx_d         = 3'd0;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A dropped write has priority over a clear in the same cycle.
        if (wr && !push) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        // done is registered, so it is raised for the cycle that will be the
        // last cycle of the final stop bit.
        done_d = (state_d == STOP) && (cnt_d == presc_d) && (!stop2_d || stop_second_d);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            presc_q       <= '0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
            idx_q         <= 3'd0;
            shift_q       <= 8'd0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            presc_q       <= presc_d;
            stop2_q       <= stop2_d;
            stop_second_q <= stop_second_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define valid contents.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo (DEPTH=8, PRESCALE_W=16). Bytes and their bit
//   period are pushed to exp_q/exp_t_q when written; a line monitor decodes
//   every frame on tx and compares it with the head of the queue.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int PW    = 16;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [7:0]    wdata;
    logic          wr;
    logic          en;
    logic [PW-1:0] prescale;
    logic          stop2;
    logic          ovf_clr;
    logic          tx;
    logic          full;
    logic          empty;
    logic [3:0]    count;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int         exp_t_q[$];
    int         mon_frames = 0;
    logic       mon_prev   = 1'b1;
    logic       mon_abort  = 1'b0;

    // ---------------- clock ----------------
    always #5 HCLK = ~HCLK;

    uart_tx_fifo #(.DEPTH(DEPTH), .PRESCALE_W(PW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .wdata     (wdata),
        .wr        (wr),
        .en        (en),
        .prescale  (prescale),
        .stop2     (stop2),
        .ovf_clr   (ovf_clr),
        .tx        (tx),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- line monitor / scoreboard ----------------
    task automatic mon_wait(input int n);
        for (int i = 0; i < n; i++) begin
            if (!mon_abort) begin
                @(negedge HCLK);
                if (HRESET) mon_abort = 1'b1;
            end
        end
    endtask

    task automatic mon_decode();
        logic [7:0] exp_b;
        logic [7:0] got;
        int         t;
        logic       start_ok;
        logic       stop_ok;
        mon_abort = 1'b0;
        got = 8'd0;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon_unexpected_frame: start bit seen with empty expected queue");
            exp_b = 8'd0;
            t = 16;
        end else begin
            exp_b = exp_q.pop_front();
            t = exp_t_q.pop_front();
        end
        mon_wait(t / 2);
        start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            mon_wait(t);
            got[i] = tx;
        end
        mon_wait(t);
        stop_ok = (tx === 1'b1);
        if (mon_abort) begin
            $display("monitor: frame for %02h discarded by reset", exp_b);
        end else begin
            total++;
            if (!start_ok || !stop_ok || got !== exp_b) begin
                bad++;
                $display("FAIL mon_frame: got byte %02h start_ok=%0b stop_ok=%0b, expected byte %02h",
                         got, start_ok, stop_ok, exp_b);
            end
            mon_frames++;
        end
    endtask

    initial begin : line_monitor
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                mon_prev = 1'b1;
            end else if (mon_prev && tx === 1'b0) begin
                mon_decode();
                mon_prev = 1'b1;
            end else begin
                mon_prev = tx;
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge HCLK);
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (ovf !== 1'b0)      begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        total++; if (count !== 4'd0)    begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full: got %b expected 0", full); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        HRESET = 1'b0;
    endtask

    // 0x55, 16-cycle bits, one stop bit: 160-cycle frame, done on its last cycle.
    task automatic test_single_frame();
        logic [7:0] byte_v;
        logic       exp_tx;
        int         b;
        byte_v = 8'h55;
        prescale = 16'd15;
        stop2 = 1'b0;
        @(negedge HCLK);
        en = 1'b1; wr = 1'b1; wdata = byte_v;
        exp_q.push_back(byte_v); exp_t_q.push_back(16);
        @(negedge HCLK);
        wr = 1'b0;
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count_after_push: got %0d expected 1", count); end
        total++; if (tx !== 1'b1)    begin bad++; $display("FAIL single_tx_before_start: got %b expected 1", tx); end
        for (int k = 1; k <= 160; k++) begin
            @(negedge HCLK);
            b = (k - 1) / 16;
            if (b == 0) exp_tx = 1'b0;
            else if (b <= 8) exp_tx = byte_v[b-1];
            else exp_tx = 1'b1;
            total++;
            if (tx !== exp_tx) begin bad++; $display("FAIL single_tx cycle %0d: got %b expected %b", k, tx, exp_tx); end
            total++;
            if (done !== (k == 160)) begin bad++; $display("FAIL single_done cycle %0d: got %b expected %b", k, done, (k == 160)); end
        end
        @(negedge HCLK);
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_end: got %b expected 1", empty); end
        en = 1'b0;
    endtask

    // Fill with en=0, overflow on the 9th, then drain back-to-back.
    task automatic test_overflow_back_to_back();
        int model_cnt;
        int gaps;
        int dones;
        int frames0;
        model_cnt = 0;
        prescale = 16'd1;
        stop2 = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge HCLK);
            if (i == 8) begin
                total++; if (full !== 1'b1)  begin bad++; $display("FAIL ovf_full_after_8: got %b expected 1", full); end
                total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL ovf_before_drop: got %b expected 0", ovf); end
            end
            wr = 1'b1; wdata = 8'(i);
            if (model_cnt < DEPTH) begin
                exp_q.push_back(8'(i)); exp_t_q.push_back(2);
                model_cnt++;
            end
        end
        @(negedge HCLK);
        wr = 1'b0;
        total++; if (ovf !== 1'b1)    begin bad++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        total++; if (count !== 4'd8)  begin bad++; $display("FAIL ovf_count: got %0d expected 8", count); end
        frames0 = mon_frames;
        en = 1'b1;
        gaps = 0;
        dones = 0;
        for (int k = 1; k <= 160; k++) begin
            @(negedge HCLK);
            if (busy !== 1'b1) gaps++;
            if (done === 1'b1) dones++;
        end
        @(negedge HCLK);
        total++; if (gaps != 0)      begin bad++; $display("FAIL b2b_idle_cycles: got %0d expected 0", gaps); end
        total++; if (dones != 8)     begin bad++; $display("FAIL b2b_done_pulses: got %0d expected 8", dones); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty_end: got %b expected 1", empty); end
        total++; if (mon_frames - frames0 != 8) begin bad++; $display("FAIL b2b_frames: got %0d expected 8", mon_frames - frames0); end
        ovf_clr = 1'b1;
        @(negedge HCLK);
        ovf_clr = 1'b0;
        total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
        en = 1'b0;
    endtask

    // Two stop bits, 4-cycle bits: 44-cycle frame; stop2 dropped mid-frame.
    task automatic test_stop2();
        logic [7:0] byte_v;
        logic       exp_tx;
        int         b;
        byte_v = 8'hA3;
        prescale = 16'd3;
        stop2 = 1'b1;
        @(negedge HCLK);
        en = 1'b1; wr = 1'b1; wdata = byte_v;
        exp_q.push_back(byte_v); exp_t_q.push_back(4);
        @(negedge HCLK);
        wr = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            @(negedge HCLK);
            if (k == 20) stop2 = 1'b0;
            b = (k - 1) / 4;
            if (b == 0) exp_tx = 1'b0;
            else if (b <= 8) exp_tx = byte_v[b-1];
            else exp_tx = 1'b1;
            total++;
            if (tx !== exp_tx) begin bad++; $display("FAIL stop2_tx cycle %0d: got %b expected %b", k, tx, exp_tx); end
            total++;
            if (done !== (k == 44)) begin bad++; $display("FAIL stop2_done cycle %0d: got %b expected %b", k, done, (k == 44)); end
        end
        @(negedge HCLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop2_busy_end: got %b expected 0", busy); end
        en = 1'b0;
    endtask

    // Push while full on the frame-end pop edge; ovf_clr against a drop.
    task automatic test_full_push_pop();
        int waited;
        logic seen;
        prescale = 16'd3;
        stop2 = 1'b0;
        @(negedge HCLK);
        en = 1'b1; wr = 1'b1; wdata = 8'h10;
        exp_q.push_back(8'h10); exp_t_q.push_back(4);
        for (int i = 1; i <= 8; i++) begin
            @(negedge HCLK);
            wdata = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i)); exp_t_q.push_back(4);
        end
        @(negedge HCLK);
        wr = 1'b0;
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count_full: got %0d expected 8", count); end
        total++; if (full !== 1'b1)  begin bad++; $display("FAIL fpp_full: got %b expected 1", full); end
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 100) begin
            @(negedge HCLK);
            waited++;
            if (done === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL fpp_done_timeout: got no done in %0d cycles expected one", waited); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fpp_full_at_end: got %b expected 1", full); end
        wr = 1'b1; wdata = 8'hC9;
        exp_q.push_back(8'hC9); exp_t_q.push_back(4);
        @(negedge HCLK);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count_after_swap: got %0d expected 8", count); end
        total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL fpp_ovf_after_swap: got %b expected 0", ovf); end
        wdata = 8'hEE; ovf_clr = 1'b1;
        @(negedge HCLK);
        wr = 1'b0; ovf_clr = 1'b0;
        total++; if (ovf !== 1'b1)   begin bad++; $display("FAIL fpp_ovf_set_wins: got %b expected 1", ovf); end
        total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count_after_drop: got %0d expected 8", count); end
        ovf_clr = 1'b1;
        @(negedge HCLK);
        ovf_clr = 1'b0;
        total++; if (ovf !== 1'b0)   begin bad++; $display("FAIL fpp_ovf_clear: got %b expected 0", ovf); end
        waited = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && waited < 800) begin
            @(negedge HCLK);
            waited++;
        end
        total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL fpp_drain_timeout: got %0d pending busy=%b expected 0 pending", exp_q.size(), busy); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fpp_empty_end: got %b expected 1", empty); end
        en = 1'b0;
    endtask

    // prescale changed mid-frame: this frame 16-cycle bits, next 4-cycle bits.
    task automatic test_prescale_change();
        int d1;
        int d2;
        prescale = 16'd15;
        stop2 = 1'b0;
        d1 = -1;
        d2 = -1;
        @(negedge HCLK);
        en = 1'b1; wr = 1'b1; wdata = 8'h96;
        exp_q.push_back(8'h96); exp_t_q.push_back(16);
        @(negedge HCLK);
        wdata = 8'h3C;
        exp_q.push_back(8'h3C); exp_t_q.push_back(4);
        @(negedge HCLK);
        wr = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL presc_busy_start: got %b expected 1", busy); end
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge HCLK);
            if (k == 40) prescale = 16'd3;
            if (done === 1'b1) begin d1 = k; break; end
        end
        total++; if (d1 != 160) begin bad++; $display("FAIL presc_frame1_len: got %0d expected 160", d1); end
        for (int k = 1; k <= 100; k++) begin
            @(negedge HCLK);
            if (done === 1'b1) begin d2 = k; break; end
        end
        total++; if (d2 != 40) begin bad++; $display("FAIL presc_frame2_len: got %0d expected 40", d2); end
        @(negedge HCLK);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL presc_busy_end: got %b expected 0", busy); end
        en = 1'b0;
        prescale = 16'd15;
    endtask

    // Reset during data bit 4, then first push right after release.
    task automatic test_reset_mid_frame();
        int dones;
        int waited;
        prescale = 16'd15;
        stop2 = 1'b0;
        @(negedge HCLK);
        en = 1'b1; wr = 1'b1; wdata = 8'hA5;
        exp_q.push_back(8'hA5); exp_t_q.push_back(16);
        @(negedge HCLK);
        wdata = 8'h3C;
        exp_q.push_back(8'h3C); exp_t_q.push_back(16);
        @(negedge HCLK);
        wr = 1'b0;
        repeat (87) @(negedge HCLK);
        total++; if (tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre_bit4: got tx=%b busy=%b expected tx=0 busy=1", tx, busy); end
        #2;
        HRESET = 1'b1;
        en = 1'b0;
        #1;
        total++; if (tx !== 1'b1)    begin bad++; $display("FAIL rst_async_tx: got %b expected 1", tx); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_async_count: got %0d expected 0", count); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        dones = 0;
        repeat (3) begin
            @(negedge HCLK);
            if (done === 1'b1) dones++;
        end
        HRESET = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        wr = 1'b1; wdata = 8'h7E;
        @(negedge HCLK);
        wr = 1'b0;
        if (done === 1'b1) dones++;
        total++; if (dones != 0)     begin bad++; $display("FAIL rst_no_done: got %0d pulses expected 0", dones); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL rst_first_push: got count %0d expected 1", count); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state_idle: got %0d expected 0", dbg_state); end
        en = 1'b1;
        exp_q.push_back(8'h7E); exp_t_q.push_back(16);
        waited = 0;
        @(negedge HCLK);
        while ((busy !== 1'b0 || exp_q.size() != 0) && waited < 400) begin
            @(negedge HCLK);
            waited++;
        end
        total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_drain_timeout: got %0d pending busy=%b expected 0 pending", exp_q.size(), busy); end
        en = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        HRESET = 1'b1;
        wr = 1'b0;
        wdata = 8'd0;
        en = 1'b0;
        prescale = 16'd15;
        stop2 = 1'b0;
        ovf_clr = 1'b0;
        test_reset();
        test_single_frame();
        test_overflow_back_to_back();
        test_stop2();
        test_full_push_pop();
        test_prescale_change();
        test_reset_mid_frame();
        repeat (2) @(negedge HCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        total++;
        bad++;
        $display("FAIL watchdog: got no completion by 1000000 ns expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
